// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_filter input conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability FSM and, when DEBOUNCE_LONG_PRESS_EN
// is defined, a long-press hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // cnt holds the number of consecutive samples seen at the candidate level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              state <= IDLE_HIGH;
              level <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= WAIT_HIGH;
              cnt   <= CW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              state <= IDLE_LOW;
              level <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= WAIT_LOW;
              cnt   <= CW'(1);
            end
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          accept_low;
  logic [HW-1:0] hold;

  // The edge that produces fall must neither count nor fire a long press.
  assign accept_low = ((state == WAIT_LOW) && !s && (cnt == CNT_LAST)) ||
                      ((STABLE_CYCLES == 1) && (state == IDLE_HIGH) && !s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!level || accept_low) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold       <= hold + HW'(1);
        long_press <= (hold == HOLD_LAST);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_filter.sv
// Multi-channel debounce filter; long-press pulses are built only when
// DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .din       (din[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: vector table, hand-written corner sequences and
// random stimulus against a run-length reference model.
module tb_debounce_filter;
  import debounce_pkg::*;

  localparam int CH     = 2;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 16;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] din = '0;
  logic [CH-1:0] level, rise, fall, long_press;

  always #5 clk = ~clk;

  debounce_filter #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG)
  ) u_dut (
    .clk(clk), .rst(rst), .din(din),
    .level(level), .rise(rise), .fall(fall), .long_press(long_press)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: level flips after STABLE consecutive delayed samples disagree
  logic [CH-1:0] dq[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_lp;
  int            run  [CH];
  int            hold [CH];

  task automatic model_reset();
    dq.delete();
    for (int k = 0; k < SYNC; k++) dq.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_lp = '0;
    for (int c = 0; c < CH; c++) begin run[c] = 0; hold[c] = 0; end
  endtask

  task automatic model_step(input logic [CH-1:0] d);
    logic [CH-1:0] s;
    s = dq.pop_front();
    dq.push_back(d);
    m_rise = '0; m_fall = '0; m_lp = '0;
    for (int c = 0; c < CH; c++) begin
      if (s[c] != m_level[c]) begin
        run[c]++;
        if (run[c] == STABLE) begin
          run[c] = 0;
          m_level[c] = s[c];
          if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
      if (m_rise[c] || m_fall[c]) hold[c] = 0;
      else if (m_level[c] && hold[c] < LONG) begin
        hold[c]++;
        m_lp[c] = LP_EN && (hold[c] == LONG);
      end
    end
  endtask

  // driver: apply din, one clock, compare against the model
  task automatic step(input logic [CH-1:0] d);
    din = d;
    @(posedge clk);
    #1;
    model_step(d);
    chk("model_level", 8'(level), 8'(m_level));
    chk("model_rise",  8'(rise),  8'(m_rise));
    chk("model_fall",  8'(fall),  8'(m_fall));
    chk("model_long",  8'(long_press), 8'(m_lp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [CH-1:0] din;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lp_cnt, lp_idx, rise_idx;
    logic [CH-1:0] d;

    // clean press (edges 1..8) then release (edges 9..16)
    for (int i = 0; i < 16; i++) begin
      tbl[i].din   = (i < 8) ? 2'b01 : 2'b00;
      tbl[i].level = ((i >= 5) && (i < 13)) ? 2'b01 : 2'b00;
      tbl[i].rise  = (i == 5)  ? 2'b01 : 2'b00;
      tbl[i].fall  = (i == 13) ? 2'b01 : 2'b00;
    end

    rst = 1'b1;
    #12;
    chk("reset_level", 8'(level), 8'h0);
    chk("reset_pulses", 8'({rise, fall, long_press}), 8'h0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].din);
      chk("tbl_level", 8'(level), 8'(tbl[i].level));
      chk("tbl_rise",  8'(rise),  8'(tbl[i].rise));
      chk("tbl_fall",  8'(fall),  8'(tbl[i].fall));
    end

    // glitch of 3 cycles is rejected
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b01);
    chk("glitch_wait_state", 8'(u_dut.g_ch[0].u_ch.state), 8'(WAIT_HIGH));
    for (int i = 0; i < 8; i++) begin
      step(2'b00);
      chk("glitch_outputs", 8'({level, rise, fall}), 8'h0);
    end
    chk("glitch_idle_state", 8'(u_dut.g_ch[0].u_ch.state), 8'(IDLE_LOW));

    // asynchronous reset during WAIT_HIGH with cnt = 2, channel 1 already high
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b10);
    chk("midwait_ch1_high", 8'(level), 8'h2);
    for (int i = 0; i < 4; i++) step(2'b11);
    chk("midwait_cnt", 8'(u_dut.g_ch[0].u_ch.cnt), 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("midwait_async_outputs", 8'({level, rise, fall, long_press}), 8'h0);
    chk("midwait_async_state", 8'(u_dut.g_ch[0].u_ch.state), 8'(IDLE_LOW));
    chk("midwait_async_cnt", 8'(u_dut.g_ch[0].u_ch.cnt), 8'd0);
    #1 rst = 1'b0;
    model_reset();
    // both channels rise together after the reset: one shared pulse cycle
    for (int i = 0; i < 8; i++) begin
      step(2'b11);
      chk("dual_rise", 8'(rise), (i == 5) ? 8'h3 : 8'h0);
    end

    // long press held
    do_reset();
    lp_cnt = 0; lp_idx = -1; rise_idx = -1;
    for (int i = 0; i < 40; i++) begin
      step(2'b01);
      if (rise[0]) rise_idx = i;
      if (long_press[0]) begin lp_cnt++; lp_idx = i; end
    end
    chk("long_rise_idx", 8'(rise_idx), 8'd5);
    chk("long_pulse_count", 8'(lp_cnt), LP_EN ? 8'd1 : 8'd0);
    chk("long_pulse_idx", 8'(lp_idx), LP_EN ? 8'(5 + LONG) : 8'hff);

    // release 10 cycles after rise: no long press
    do_reset();
    lp_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step((i < 15) ? 2'b01 : 2'b00);
      if (long_press[0]) lp_cnt++;
    end
    chk("short_press_no_long", 8'(lp_cnt), 8'd0);
    chk("short_press_released", 8'(level), 8'h0);

    // random stimulus with occasional asynchronous reset
    do_reset();
    d = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
      if (($urandom_range(0, 29) == 0) && (i % 40 < 20)) d = '1;
      step(d);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand_async_reset", 8'({level, rise, fall, long_press}), 8'h0);
        #1 rst = 1'b0;
        model_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
